mips_mem_arbiter: RTL
=====================

# mips_mem_arbiter

Single-port memory arbiter for the MIPS core. Shares one unified instruction/data memory port between the instruction-fetch requester and the load/store requester. Data accesses win by default. A streak counter keeps a continuous run of loads and stores from starving fetch. Sits between the core's fetch/memory stages and the memory model instantiated under the `mips` top level.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` wide.
- `MAX_DATA_STREAK`, 4, max consecutive data grants while fetch waits (≥1).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ack`, held otherwise.
- `dm_req`  in  1  data request; held until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_be`  in  DATA_W/8  store byte enables.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_ack`  out  1  one-cycle data completion pulse.
- `dm_rdata`  out  DATA_W  load data; valid while `dm_ack`; 0 on store responses; held otherwise.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  memory write strobe.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_ack`  in  1  memory completion; read data valid in the same cycle.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- **IDLE, arbitration at the clock edge:**
  - `dm_req` alone → BUSY_DM.
  - `if_req` alone → BUSY_IF.
  - Both high → BUSY_DM, unless `streak == MAX_DATA_STREAK`; then → BUSY_IF.
  - Neither → stay in IDLE.
- **Request latch:** on the grant edge, latch address, we, be and wdata into the request registers.
  - Fetch grants force `we=0` and `be=all-ones`.
- **BUSY_x:**
  - `mem_req=1`; `mem_*` are driven from the request registers, stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata` into the granted requester's rdata register and go to RESP. For a store, capture 0 into `dm_rdata` instead.
- **RESP:**
  - Pulse `if_ack` or `dm_ack` (the granted one) for exactly 1 cycle.
  - `mem_req=0`.
  - → IDLE.
- **Streak counter:** width `$clog2(MAX_DATA_STREAK+1)`.
  - +1 on a DM grant while `if_req=1`, saturating at MAX.
  - Cleared on any IF grant.
  - Cleared on a DM grant while `if_req=0`.
- **Outside BUSY_x:**
  - `mem_req=0` and `mem_we=0`.
  - `mem_addr`, `mem_be` and `mem_wdata` hold their last values.
  - `mem_ack` is ignored.
- **Requester obligations:** `x_req` and its payload stay stable from assertion until the cycle of `x_ack`. The requester may drop or re-issue at the edge that ends the ack cycle.
- **Reset:** when `reset=0`, the block enters IDLE immediately (asynchronously).
  - All outputs go to 0, including rdata registers and streak.
  - An in-flight `mem_req` is abandoned mid-access. The memory model must tolerate this.

## Timing
- Zero-wait memory (`mem_ack` in the first BUSY cycle):
  - request sampled at edge 0;
  - `mem_req` high in cycle 1;
  - `x_ack` high in cycle 2;
  - IDLE again in cycle 3.
- Throughput: 3 cycles per access.
- With W memory wait cycles, `x_ack` comes 2+W cycles after the sampling edge.
- `mem_ack` in the same cycle a new IDLE grant is decided is impossible; there is no combinational path from any input to `mem_req`.
- All outputs are registered or decoded from state only. No input→output combinational path exists.
- Simultaneous `if_req` and `dm_req` arriving in the RESP cycle are arbitrated at the following IDLE edge, not in RESP.
- A requester whose request is rejected at an edge keeps its request up and is re-arbitrated at the next IDLE.

## Test plan
- **Reset values:** hold `reset=0` for 2 cycles with random inputs → every output 0 and `busy=0`; release → IDLE.
- **Single fetch, zero-wait:**
  - Stimulus: `if_addr=0x0000_0040`; memory returns `0x2008_0005`.
  - Required: `mem_req` in cycle 1 with `mem_we=0` and `mem_be=4'hF`; `if_ack=1` and `if_rdata=0x2008_0005` in cycle 2; IDLE in cycle 3.
- **Store with 3 wait cycles:**
  - Stimulus: `dm_we=1`, `dm_be=4'b0011`, `dm_addr=0x100`, `dm_wdata=0xDEAD_BEEF`.
  - Required: `mem_*` stable for 4 cycles; `dm_ack` in cycle 5; `dm_rdata=0`; `if_ack` stays 0.
- **Streak limit:**
  - Stimulus: `if_req` and `dm_req` both held high continuously with `MAX_DATA_STREAK=4`.
  - Required: grant sequence DM, DM, DM, DM, IF, DM, DM, DM, DM, IF.
  - Then drop `if_req` for one DM grant → streak cleared.
- **Reset mid-access:**
  - Stimulus: assert `reset=0` mid-cycle during BUSY_DM with `mem_ack` still low.
  - Required: `mem_req` falls without waiting for a clock edge; no `dm_ack` is ever produced for that request.
  - After release, a re-issued `dm_req` completes normally.
- **Stray acknowledge:** `mem_ack=1` while in IDLE or RESP → no ack pulse, no rdata change, state unchanged.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: instruction fetch and load/store share one memory port.
// Data wins by default; a saturating streak counter hands the port to a waiting fetch.
module mips_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_e;

  state_e              state_q, state_d;
  logic                gntDm_q, gntDm_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0]   dmRdata_q, dmRdata_d;
  logic                limitHit;

  assign limitHit = (streak_q == STREAK_W'(MAX_DATA_STREAK));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gntDm_q   <= 1'b0;
      streak_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      ifRdata_q <= '0;
      dmRdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gntDm_q   <= gntDm_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ifRdata_q <= ifRdata_d;
      dmRdata_q <= dmRdata_d;
    end
  end

  // Arbitration only happens in IDLE; requests seen in RESP wait for the next IDLE edge.
  always_comb begin
    state_d   = state_q;
    gntDm_d   = gntDm_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    ifRdata_d = ifRdata_q;
    dmRdata_d = dmRdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req && !(if_req && limitHit)) begin
          state_d  = BUSY_DM;
          gntDm_d  = 1'b1;
          addr_d   = dm_addr;
          we_d     = dm_we;
          be_d     = dm_be;
          wdata_d  = dm_wdata;
          if (if_req)
            streak_d = limitHit ? streak_q : streak_q + STREAK_W'(1);
          else
            streak_d = '0;
        end else if (if_req) begin
          state_d  = BUSY_IF;
          gntDm_d  = 1'b0;
          addr_d   = if_addr;
          we_d     = 1'b0;
          be_d     = '1;
          wdata_d  = '0;
          streak_d = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d   = RESP;
          ifRdata_d = mem_rdata;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          state_d   = RESP;
          dmRdata_d = we_q ? '0 : mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a register or a decode of state, so no input reaches an output combinationally.
  assign mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) && !gntDm_q;
  assign dm_ack    = (state_q == RESP) && gntDm_q;
  assign if_rdata  = ifRdata_q;
  assign dm_rdata  = dmRdata_q;
  assign busy      = (state_q != IDLE);

endmodule
